// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between fetch and data ports: fetch/read and RMW store take 3 cycles, aligned word store 2, plus one IDLE.
// Requests are held by the requester until its valid pulse; contention alternates between the two sides.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_data,
  output logic                  i_valid,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_addr,
  input  logic [1:0]            d_width,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_valid,
  output logic                  d_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DREAD, DWRITE, RMW_RD, RMW_WR, RD_WAIT, RESP
  } state_t;

  typedef struct packed {
    logic                  is_data;
    logic                  oor;
    logic [1:0]            width;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word;
    logic [31:0]           wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic   last_grant_d;
  logic   d_pend, grant_d, grant_i, d_oor, d_aligned;
  logic [31:0] shifted, merged;
  logic [3:0]  lane_base, lane;

  // Fetch addresses wrap, so their upper and byte-offset bits are ignored.
  logic unused_ok;
  assign unused_ok = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0]};

  assign d_pend    = d_read | d_write;
  assign grant_d   = d_pend && (!i_req || !last_grant_d);
  assign grant_i   = i_req && !grant_d;
  assign d_oor     = (d_addr[31:2] >> ADDR_WIDTH) != '0;
  assign d_aligned = d_width[1] && (d_addr[1:0] == 2'd0);
  assign mem_addr  = req_q.word;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          if (d_oor)        state_nxt = RESP;
          else if (d_write) state_nxt = d_aligned ? DWRITE : RMW_RD;
          else              state_nxt = DREAD;
        end else if (grant_i) begin
          state_nxt = FETCH;
        end
      end
      FETCH, DREAD: state_nxt = RD_WAIT;
      RD_WAIT:      state_nxt = RESP;
      DWRITE:       state_nxt = RESP;
      RMW_RD:       state_nxt = RMW_WR;
      RMW_WR:       state_nxt = RESP;
      default:      state_nxt = IDLE;
    endcase
  end

  // Byte-lane merge for partial stores; lanes shifted past byte 3 fall off.
  always_comb begin
    shifted = req_q.wdata << {req_q.off, 3'b000};
    case (req_q.width)
      2'd0:    lane_base = 4'b0001;
      2'd1:    lane_base = 4'b0011;
      default: lane_base = 4'b1111;
    endcase
    lane = lane_base << req_q.off;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = lane[b] ? shifted[8*b +: 8] : mem_rdata[8*b +: 8];
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    d_error   = 1'b0;
    case (state)
      FETCH, DREAD, RMW_RD: mem_en = 1'b1;
      DWRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = req_q.wdata;
      end
      RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      RESP: begin
        i_valid = !req_q.is_data;
        d_valid = req_q.is_data;
        d_error = req_q.is_data && req_q.oor;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q        <= '0;
      last_grant_d <= 1'b0;
      i_data       <= '0;
      d_rdata      <= '0;
    end else begin
      if (state == IDLE && grant_d) begin
        last_grant_d <= 1'b1;
        req_q <= '{is_data: 1'b1, oor: d_oor, width: d_width, off: d_addr[1:0],
                   word: d_addr[ADDR_WIDTH+1:2], wdata: d_wdata};
        if (d_write || d_oor) d_rdata <= '0;
      end else if (state == IDLE && grant_i) begin
        last_grant_d <= 1'b0;
        req_q <= '{is_data: 1'b0, oor: 1'b0, width: 2'd0, off: 2'd0,
                   word: i_addr[ADDR_WIDTH+1:2], wdata: 32'd0};
      end
      if (state == RD_WAIT) begin
        if (req_q.is_data) d_rdata <= mem_rdata >> {req_q.off, 3'b000};
        else               i_data  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model predicting every output cycle, plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [31:0]   i_data;
  logic          i_valid;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [1:0]    d_width = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          d_error;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_width(d_width),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_error(d_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram       [0:(1<<AW)-1];
  logic [31:0] model_mem [0:(1<<AW)-1];

  always @(posedge clock) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          en, we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          iv, dv, de;
    logic [31:0]   idat, drd;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t rec(input logic en, input logic we, input logic [AW-1:0] a,
                               input logic [31:0] wd, input logic iv, input logic dv,
                               input logic de, input logic [31:0] idat, input logic [31:0] drd);
    exp_t r;
    r.en = en; r.we = we; r.addr = a; r.wd = wd;
    r.iv = iv; r.dv = dv; r.de = de; r.idat = idat; r.drd = drd;
    return r;
  endfunction

  // Store semantics: byte j of the data lands in byte (offset+j); anything beyond byte 3 is lost.
  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                              input int off, input logic [1:0] w);
    logic [31:0] r;
    int n;
    r = old;
    n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    for (int j = 0; j < n; j++)
      if (off + j < 4) r[8*(off+j) +: 8] = wd[8*j +: 8];
    return r;
  endfunction

  // Model: whenever nothing is outstanding, the current edge is an arbitration point.
  bit            m_last_d = 1'b0;
  bit            cmp_on = 1'b0;
  logic [AW-1:0] m_idx;
  logic [31:0]   m_new;
  int            m_off;

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_last_d = 1'b0;
      cmp_on = 1'b1;
    end else if (exp_q.size() == 0) begin
      if ((d_read || d_write) && (!i_req || !m_last_d)) begin
        m_last_d = 1'b1;
        m_off = int'(d_addr[1:0]);
        if (d_addr[31:2] >= 30'(1 << AW)) begin
          exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0, '0));
        end else begin
          m_idx = d_addr[AW+1:2];
          if (d_write) begin
            m_new = apply_store(model_mem[m_idx], d_wdata, m_off, d_width);
            model_mem[m_idx] = m_new;
            if (d_width >= 2'd2 && m_off == 0) begin
              exp_q.push_back(rec(1'b1, 1'b1, m_idx, m_new, 1'b0, 1'b0, 1'b0, '0, '0));
            end else begin
              exp_q.push_back(rec(1'b1, 1'b0, m_idx, '0, 1'b0, 1'b0, 1'b0, '0, '0));
              exp_q.push_back(rec(1'b1, 1'b1, m_idx, m_new, 1'b0, 1'b0, 1'b0, '0, '0));
            end
            exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0));
          end else begin
            exp_q.push_back(rec(1'b1, 1'b0, m_idx, '0, 1'b0, 1'b0, 1'b0, '0, '0));
            exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0));
            exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0,
                                model_mem[m_idx] >> (8 * m_off)));
          end
        end
        exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0));
      end else if (i_req) begin
        m_last_d = 1'b0;
        m_idx = i_addr[AW+1:2];
        exp_q.push_back(rec(1'b1, 1'b0, m_idx, '0, 1'b0, 1'b0, 1'b0, '0, '0));
        exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0));
        exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, model_mem[m_idx], '0));
        exp_q.push_back(rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0));
      end
    end
  end

  exp_t ce;
  always @(negedge clock) begin
    if (cmp_on) begin
      if (exp_q.size() != 0) ce = exp_q.pop_front();
      else ce = rec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("cyc mem_en", 32'(mem_en), 32'(ce.en));
      chk("cyc mem_we", 32'(mem_we), 32'(ce.we));
      chk("cyc i_valid", 32'(i_valid), 32'(ce.iv));
      chk("cyc d_valid", 32'(d_valid), 32'(ce.dv));
      chk("cyc d_error", 32'(d_error), 32'(ce.de));
      if (ce.en) chk("cyc mem_addr", 32'(mem_addr), 32'(ce.addr));
      if (ce.we) chk("cyc mem_wdata", mem_wdata, ce.wd);
      if (ce.iv) chk("cyc i_data", i_data, ce.idat);
      if (ce.dv) chk("cyc d_rdata", d_rdata, ce.drd);
    end
  end

  // One access: latency counts negedges from the IDLE cycle in which the request is raised.
  task automatic access(input logic fetch, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [1:0] width, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output logic err,
                        output int en_n, output int we_n, output logic [31:0] wlast);
    bit done;
    done = 1'b0;
    @(posedge clock); #1;
    if (fetch) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_read = rd; d_write = wr; d_addr = addr; d_width = width; d_wdata = wdata;
    end
    lat = 0; en_n = 0; we_n = 0; wlast = '0; rdata = '0; err = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      if (mem_en) en_n++;
      if (mem_we) begin we_n++; wlast = mem_wdata; end
      if (fetch ? i_valid : d_valid) begin
        done = 1'b1;
        rdata = fetch ? i_data : d_rdata;
        err = d_error;
      end
    end
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    chk("access completes", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] r, wl;
  logic        err;
  int          lat, en_n, we_n, iv_n;
  byte         glog[$];

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      ram[k] = 32'h5A00_0000 | 32'(k);
      model_mem[k] = 32'h5A00_0000 | 32'(k);
    end
    ram[5] = 32'hAABBCCDD; model_mem[5] = 32'hAABBCCDD;
    ram[6] = 32'h01234567; model_mem[6] = 32'h01234567;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset i_valid", 32'(i_valid), 32'd0);
    chk("reset d_valid", 32'(d_valid), 32'd0);
    chk("reset d_error", 32'(d_error), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset i_data", i_data, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);

    access(1'b1, 1'b0, 1'b0, 32'h14, 2'd2, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("fetch data", r, 32'hAABBCCDD);
    chk("fetch latency", 32'(lat), 32'd4);
    chk("fetch en cycles", 32'(en_n), 32'd1);

    access(1'b0, 1'b1, 1'b0, 32'h16, 2'd1, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("half read data", r, 32'h0000AABB);
    chk("half read latency", 32'(lat), 32'd4);

    access(1'b0, 1'b0, 1'b1, 32'h15, 2'd0, 32'h11, r, lat, err, en_n, we_n, wl);
    chk("byte rmw wdata", wl, 32'hAABB11DD);
    chk("byte rmw we cycles", 32'(we_n), 32'd1);
    chk("byte rmw en cycles", 32'(en_n), 32'd2);
    chk("byte rmw latency", 32'(lat), 32'd4);
    access(1'b0, 1'b1, 1'b0, 32'h14, 2'd2, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("readback after byte", r, 32'hAABB11DD);

    ram[5] = 32'hAABBCCDD; model_mem[5] = 32'hAABBCCDD;
    access(1'b0, 1'b0, 1'b1, 32'h17, 2'd1, 32'h5566, r, lat, err, en_n, we_n, wl);
    chk("half at offset 3 word5", ram[5], 32'h66BBCCDD);
    chk("half at offset 3 word6", ram[6], 32'h01234567);

    access(1'b0, 1'b0, 1'b1, 32'h20, 2'd2, 32'hDEADBEEF, r, lat, err, en_n, we_n, wl);
    chk("word write latency", 32'(lat), 32'd3);
    chk("word write we cycles", 32'(we_n), 32'd1);
    chk("word write ram", ram[8], 32'hDEADBEEF);

    access(1'b0, 1'b0, 1'b1, 32'h0010_0000, 2'd2, 32'h12345678, r, lat, err, en_n, we_n, wl);
    chk("oor write error", 32'(err), 32'd1);
    chk("oor write latency", 32'(lat), 32'd2);
    chk("oor write en cycles", 32'(en_n), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h0001_0000, 2'd2, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("oor boundary error", 32'(err), 32'd1);
    chk("oor boundary rdata", r, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_FFFC, 2'd2, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("last word error", 32'(err), 32'd0);
    chk("last word data", r, 32'h5A003FFF);

    access(1'b1, 1'b0, 1'b0, 32'h0001_0014, 2'd2, 32'd0, r, lat, err, en_n, we_n, wl);
    chk("fetch wraps", r, 32'h66BBCCDD);

    access(1'b0, 1'b1, 1'b1, 32'h24, 2'd2, 32'h12345678, r, lat, err, en_n, we_n, wl);
    chk("read+write rdata", r, 32'd0);
    chk("read+write latency", 32'(lat), 32'd3);
    chk("read+write ram", ram[9], 32'h12345678);

    access(1'b0, 1'b0, 1'b1, 32'h2A, 2'd3, 32'hCAFEF00D, r, lat, err, en_n, we_n, wl);
    chk("word at offset 2", ram[10], 32'hF00D000A);

    // Contention straight after reset: data side first, then strict alternation.
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h14;
    d_read = 1'b1; d_addr = 32'h20; d_width = 2'd2;
    glog.delete();
    for (int c = 0; c < 40 && glog.size() < 4; c++) begin
      @(negedge clock);
      if (d_valid) glog.push_back(8'h44);
      if (i_valid) glog.push_back(8'h49);
    end
    i_req = 1'b0; d_read = 1'b0;
    chk("alternation count", 32'(glog.size()), 32'd4);
    if (glog.size() >= 4) begin
      chk("grant 0 is D", 32'(glog[0]), 32'h44);
      chk("grant 1 is I", 32'(glog[1]), 32'h49);
      chk("grant 2 is D", 32'(glog[2]), 32'h44);
      chk("grant 3 is I", 32'(glog[3]), 32'h49);
    end

    // Reset during C1 of a fetch aborts it.
    @(posedge clock); #1;
    i_req = 1'b1; i_addr = 32'h14;
    @(negedge clock);
    @(negedge clock);
    chk("abort C1 mem_en", 32'(mem_en), 32'd1);
    reset = 1'b1; i_req = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort mem_en after reset", 32'(mem_en), 32'd0);
    iv_n = 0;
    repeat (6) begin
      @(negedge clock);
      if (i_valid) iv_n++;
    end
    chk("abort no i_valid", 32'(iv_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
